decode_stage: RTL and testbench

- Instruction-decode pipeline stage sitting directly upstream of regFile.
- Accepts fetched instructions over a valid/ready handshake and drives regFile read addresses (addrA/addrB).
- Registers the decoded fields, immediate and returned operands (data_a/data_b) into a decode/execute pipeline register.
- Keeps a scoreboard of in-flight destination registers and stalls on RAW/WAW hazards until writeback retires them.

---
 rtl/decode_stage_pkg.sv | 54 +++++
 rtl/decode_stage_imm_gen.sv | 32 +++
 rtl/decode_stage.sv | 136 +++++++++++++
 tb/tb_decode_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared constants and decode helpers for the decode stage and its regFile neighbour.
package decode_stage_pkg;

  localparam int ADDR_WIDTH     = 5;
  localparam int REG_FILE_WIDTH = 32;
  localparam int REG_FILE_NREG  = 32;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Which register fields an instruction class actually reads or writes.
  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic use_rd;
    logic illegal;
  } reg_use_t;

  // Unknown opcodes touch no registers so they can never cause a stall.
  function automatic reg_use_t decode_use(input logic [6:0] opcode);
    reg_use_t u;
    u = '0;
    case (opcode)
      OPC_R: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
        u.use_rd  = 1'b1;
      end
      OPC_IMM, OPC_LOAD, OPC_JALR: begin
        u.use_rs1 = 1'b1;
        u.use_rd  = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        u.use_rs1 = 1'b1;
        u.use_rs2 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        u.use_rd = 1'b1;
      end
      default: begin
        u.illegal = 1'b1;
      end
    endcase
    return u;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational sign-extended immediate generator; unknown opcodes and R-type yield zero.
module imm_gen
  import decode_stage_pkg::*;
(
  input  logic [REG_FILE_WIDTH-1:0] instr,
  output logic [REG_FILE_WIDTH-1:0] imm
);

  logic [6:0] opcode;

  assign opcode = instr[6:0];

  // Select the immediate format from the opcode class.
  always_comb begin
    imm = '0;
    case (opcode)
      OPC_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: drives regFile read addresses, tracks in-flight
// destinations in a busy scoreboard and registers decoded fields for execute.
module decode_stage #(
  parameter int ADDR_WIDTH     = decode_stage_pkg::ADDR_WIDTH,
  parameter int REG_FILE_WIDTH = decode_stage_pkg::REG_FILE_WIDTH,
  parameter int REG_FILE_NREG  = decode_stage_pkg::REG_FILE_NREG
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [REG_FILE_WIDTH-1:0] in_instr,
  input  logic [REG_FILE_WIDTH-1:0] in_pc,
  output logic [ADDR_WIDTH-1:0]     addrA,
  output logic [ADDR_WIDTH-1:0]     addrB,
  input  logic [REG_FILE_WIDTH-1:0] data_a,
  input  logic [REG_FILE_WIDTH-1:0] data_b,
  input  logic                      wb_valid,
  input  logic [ADDR_WIDTH-1:0]     wb_rd,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_FILE_WIDTH-1:0] out_pc,
  output logic [6:0]                out_opcode,
  output logic [2:0]                out_funct3,
  output logic [6:0]                out_funct7,
  output logic [ADDR_WIDTH-1:0]     out_rd,
  output logic                      out_wr_en,
  output logic [REG_FILE_WIDTH-1:0] out_imm,
  output logic [REG_FILE_WIDTH-1:0] out_rs1_val,
  output logic [REG_FILE_WIDTH-1:0] out_rs2_val,
  output logic                      out_illegal
);

  import decode_stage_pkg::*;

  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [6:0]                funct7;
  logic [ADDR_WIDTH-1:0]     rd;
  logic [ADDR_WIDTH-1:0]     rs1;
  logic [ADDR_WIDTH-1:0]     rs2;
  reg_use_t                  use_info;
  logic                      wr_en;
  logic [REG_FILE_WIDTH-1:0] imm;
  logic [REG_FILE_NREG-1:0]  busy;
  logic [REG_FILE_NREG-1:0]  busy_next;
  logic                      hazard;
  logic                      transfer;
  logic                      issue;

  assign opcode   = in_instr[6:0];
  assign rd       = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];
  assign funct7   = in_instr[31:25];
  assign addrA    = rs1;
  assign addrB    = rs2;
  assign use_info = decode_use(opcode);
  assign wr_en    = use_info.use_rd && (rd != '0);

  imm_gen u_imm_gen (
    .instr (in_instr),
    .imm   (imm)
  );

  // Stall when a source or destination is still in flight, either already
  // issued (scoreboard) or sitting in the output register waiting to issue.
  always_comb begin
    hazard = 1'b0;
    if (use_info.use_rs1 && (rs1 != '0) && busy[rs1]) hazard = 1'b1;
    if (use_info.use_rs2 && (rs2 != '0) && busy[rs2]) hazard = 1'b1;
    if (wr_en && busy[rd]) hazard = 1'b1;
    if (out_valid && out_wr_en && (out_rd != '0)) begin
      if ((use_info.use_rs1 && (rs1 == out_rd)) ||
          (use_info.use_rs2 && (rs2 == out_rd)) ||
          (wr_en && (rd == out_rd))) begin
        hazard = 1'b1;
      end
    end
  end

  assign in_ready = !hazard && !flush && (!out_valid || out_ready);
  assign transfer = in_valid && in_ready;
  assign issue    = out_valid && out_ready && out_wr_en && !flush;

  // Next scoreboard value: writeback clears, issue sets, and a same-register set wins.
  always_comb begin
    busy_next = busy;
    if (wb_valid) busy_next[wb_rd] = 1'b0;
    if (issue) busy_next[out_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register of destinations issued but not yet written back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Decode/execute pipeline register: load on transfer, drain on consume or flush, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_rd      <= '0;
      out_wr_en   <= 1'b0;
      out_imm     <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_illegal <= 1'b0;
    end else if (transfer) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_opcode  <= opcode;
      out_funct3  <= funct3;
      out_funct7  <= funct7;
      out_rd      <= rd;
      out_wr_en   <= wr_en;
      out_imm     <= imm;
      out_rs1_val <= data_a;
      out_rs2_val <= data_b;
      out_illegal <= use_info.illegal;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with a fixed-content regFile model.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  addrA;
  logic [4:0]  addrB;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic [31:0] out_imm;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic        out_illegal;

  int check_count = 0;
  int error_count = 0;

  localparam logic [31:0] ADDI_X1  = 32'h00500093;
  localparam logic [31:0] ADD_X2   = 32'h00108133;
  localparam logic [31:0] ADDI_X0  = 32'h00100013;
  localparam logic [31:0] ADD_X3   = 32'h000001B3;
  localparam logic [31:0] LUI_X5   = 32'h123452B7;
  localparam logic [31:0] SW_X2    = 32'hFE20AE23;
  localparam logic [31:0] BEQ_M8   = 32'hFE000CE3;
  localparam logic [31:0] JAL_X7   = 32'h001003EF;
  localparam logic [31:0] ILLEGAL  = 32'h007382FF;
  localparam logic [31:0] ADDI_X5  = 32'h00100293;

  decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .addrA       (addrA),
    .addrB       (addrB),
    .data_a      (data_a),
    .data_b      (data_b),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_rd      (out_rd),
    .out_wr_en   (out_wr_en),
    .out_imm     (out_imm),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // regFile contents: x0 reads zero, every other register reads a tagged constant.
  function automatic logic [31:0] reg_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : (32'h10000000 | {27'd0, a});
  endfunction

  // Combinational regFile read ports.
  always_comb begin
    data_a = reg_val(addrA);
    data_b = reg_val(addrB);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = valid;
    in_instr = instr;
    in_pc    = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    applyStimulus(1'b1, ADDI_X1, 32'h100);

    // Reset held with a valid instruction present
    tick();
    tick();
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_rd", out_rd, 0);
    checkOutput("reset_out_imm", out_imm, 0);
    checkOutput("reset_out_pc", out_pc, 0);
    checkOutput("reset_busy", dut.busy, 0);
    checkOutput("reset_addrA", addrA, 0);

    // Release and accept ADDI x1,x0,5
    rst_n = 1'b1;
    applyStimulus(1'b1, ADDI_X1, 32'h100);
    checkOutput("addi_in_ready", in_ready, 1);
    tick();
    checkOutput("addi_out_valid", out_valid, 1);
    checkOutput("addi_out_rd", out_rd, 1);
    checkOutput("addi_out_wr_en", out_wr_en, 1);
    checkOutput("addi_out_imm", out_imm, 5);
    checkOutput("addi_out_pc", out_pc, 32'h100);
    checkOutput("addi_out_opcode", out_opcode, 7'h13);
    checkOutput("addi_out_rs1_val", out_rs1_val, 0);

    // RAW on x1 against the output register, then against the scoreboard
    applyStimulus(1'b1, ADD_X2, 32'h104);
    checkOutput("raw_addrA", addrA, 1);
    checkOutput("raw_addrB", addrB, 1);
    checkOutput("raw_outreg_in_ready", in_ready, 0);
    tick();
    checkOutput("raw_issue_busy", dut.busy, 32'h2);
    checkOutput("raw_drain_out_valid", out_valid, 0);
    checkOutput("raw_sb_in_ready", in_ready, 0);
    tick();
    checkOutput("raw_hold_in_ready", in_ready, 0);
    wb_valid = 1'b1;
    wb_rd    = 5'd1;
    #1;
    checkOutput("raw_wb_same_cycle_in_ready", in_ready, 0);
    tick();
    wb_valid = 1'b0;
    #1;
    checkOutput("raw_cleared_busy", dut.busy, 0);
    checkOutput("raw_cleared_in_ready", in_ready, 1);
    tick();
    checkOutput("add_out_valid", out_valid, 1);
    checkOutput("add_out_rd", out_rd, 2);
    checkOutput("add_out_rs1_val", out_rs1_val, 32'h10000001);
    checkOutput("add_out_rs2_val", out_rs2_val, 32'h10000001);
    checkOutput("add_out_opcode", out_opcode, 7'h33);
    checkOutput("add_out_imm", out_imm, 0);

    // r0 destination never enters the scoreboard
    applyStimulus(1'b1, ADDI_X0, 32'h108);
    checkOutput("r0_in_ready", in_ready, 1);
    tick();
    checkOutput("r0_out_wr_en", out_wr_en, 0);
    checkOutput("r0_out_imm", out_imm, 1);
    checkOutput("r0_busy", dut.busy, 32'h4);
    applyStimulus(1'b1, ADD_X3, 32'h10C);
    checkOutput("add_x3_in_ready", in_ready, 1);
    tick();
    checkOutput("r0_issue_busy", dut.busy, 32'h4);
    checkOutput("add_x3_out_rd", out_rd, 3);
    checkOutput("add_x3_out_wr_en", out_wr_en, 1);

    // Backpressure: output register holds, nothing issues
    out_ready = 1'b0;
    applyStimulus(1'b1, LUI_X5, 32'h110);
    checkOutput("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_out_rd", out_rd, 3);
      checkOutput("bp_out_pc", out_pc, 32'h10C);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_busy", dut.busy, 32'h4);
    end

    // Flush with out_ready high: killed, not issued
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    checkOutput("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush_out_valid", out_valid, 0);
    checkOutput("flush_busy", dut.busy, 32'h4);

    // LUI accepted while x2 retires
    wb_valid = 1'b1;
    wb_rd    = 5'd2;
    applyStimulus(1'b1, LUI_X5, 32'h110);
    checkOutput("lui_in_ready", in_ready, 1);
    tick();
    wb_valid = 1'b0;
    checkOutput("lui_out_imm", out_imm, 32'h12345000);
    checkOutput("lui_out_rd", out_rd, 5);
    checkOutput("lui_busy", dut.busy, 0);

    // Store immediate
    applyStimulus(1'b1, SW_X2, 32'h114);
    checkOutput("sw_in_ready", in_ready, 1);
    tick();
    checkOutput("sw_out_imm", out_imm, 32'hFFFFFFFC);
    checkOutput("sw_out_funct3", out_funct3, 3'd2);
    checkOutput("sw_out_wr_en", out_wr_en, 0);
    checkOutput("sw_out_rs1_val", out_rs1_val, 32'h10000001);
    checkOutput("sw_out_rs2_val", out_rs2_val, 32'h10000002);
    checkOutput("sw_busy", dut.busy, 32'h20);

    // Branch immediate
    applyStimulus(1'b1, BEQ_M8, 32'h118);
    tick();
    checkOutput("beq_out_imm", out_imm, 32'hFFFFFFF8);
    checkOutput("beq_out_funct7", out_funct7, 7'h7F);
    checkOutput("beq_out_wr_en", out_wr_en, 0);

    // Jump immediate
    applyStimulus(1'b1, JAL_X7, 32'h11C);
    tick();
    checkOutput("jal_out_imm", out_imm, 32'h00000800);
    checkOutput("jal_out_rd", out_rd, 7);
    checkOutput("jal_out_wr_en", out_wr_en, 1);

    // Illegal opcode with fields naming busy/in-flight registers; set beats clear on x7
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    applyStimulus(1'b1, ILLEGAL, 32'h120);
    checkOutput("illegal_in_ready", in_ready, 1);
    tick();
    wb_valid = 1'b0;
    #1;
    checkOutput("set_wins_busy", dut.busy, 32'hA0);
    checkOutput("illegal_out_illegal", out_illegal, 1);
    checkOutput("illegal_out_imm", out_imm, 0);
    checkOutput("illegal_out_wr_en", out_wr_en, 0);
    checkOutput("illegal_out_valid", out_valid, 1);

    // WAW on busy x5
    applyStimulus(1'b1, ADDI_X5, 32'h124);
    checkOutput("waw_in_ready", in_ready, 0);
    tick();
    checkOutput("waw_hold_in_ready", in_ready, 0);

    // Reset in the middle of the stall
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", dut.busy, 0);
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_out_illegal", out_illegal, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("postreset_in_ready", in_ready, 1);
    tick();
    checkOutput("postreset_out_valid", out_valid, 1);
    checkOutput("postreset_out_rd", out_rd, 5);
    checkOutput("postreset_out_pc", out_pc, 32'h124);

    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
